// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the hh:mm:ss clock counter.
// Walks the user through hour -> minute -> second edit fields with three
// debounced buttons, then strobes `load` for one cycle to commit the values.
// Optional build macro: AUTO_REPEAT_EN (hold-to-repeat on up/down).
module clock_set_ctrl #(
`ifdef AUTO_REPEAT_EN
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned REPEAT_CYCLES  = 10000000,
`endif
  parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] cur_second,
  input  logic [5:0] cur_minute,
  input  logic [4:0] cur_hour,
  output logic       set_active,
  output logic [1:0] sel_field,
  output logic       load,
  output logic [5:0] load_second,
  output logic [5:0] load_minute,
  output logic [4:0] load_hour
);

  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t      state, state_nxt;
  logic        mode_prev, up_prev, down_prev;
  logic        mode_e, up_e, down_e;
  logic [4:0]  hour_r;
  logic [5:0]  min_r, sec_r;
  logic [29:0] tmo_cnt;
  logic        in_set, step_up, step_dn, rpt_up, rpt_dn, any_evt, tmo_hit;

  // Button history; resets high so a button held through reset must be
  // released and pressed again before it counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_prev <= 1'b1;
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      up_prev   <= btn_up;
      down_prev <= btn_down;
    end
  end

  assign mode_e = btn_mode & ~mode_prev;
  assign up_e   = btn_up   & ~up_prev;
  assign down_e = btn_down & ~down_prev;
  assign in_set = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);

`ifdef AUTO_REPEAT_EN
  logic        rpt_armed, rpt_first, rpt_held, rpt_fire;
  logic [31:0] rpt_cnt;

  // A repeat is armed only by a fresh press of exactly one of up/down;
  // mode, release, or both-held disarms it until the next press.
  assign rpt_held = in_set & rpt_armed & (btn_up ^ btn_down) & ~mode_e & ~up_e & ~down_e;
  assign rpt_fire = rpt_held &
                    (rpt_cnt == (rpt_first ? 32'(HOLD_CYCLES - 1) : 32'(REPEAT_CYCLES - 1)));
  assign rpt_up   = rpt_fire & btn_up;
  assign rpt_dn   = rpt_fire & btn_down;

  // Hold/repeat interval counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_armed <= 1'b0;
      rpt_first <= 1'b1;
      rpt_cnt   <= '0;
    end else if (!in_set || mode_e || !(btn_up ^ btn_down)) begin
      rpt_armed <= 1'b0;
      rpt_first <= 1'b1;
      rpt_cnt   <= '0;
    end else if (up_e || down_e) begin
      rpt_armed <= 1'b1;
      rpt_first <= 1'b1;
      rpt_cnt   <= '0;
    end else if (rpt_fire) begin
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if (rpt_held) begin
      rpt_cnt   <= rpt_cnt + 32'd1;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // Mode has priority; simultaneous up+down edges cancel.
  assign step_up = ~mode_e & ((up_e & ~down_e) | rpt_up);
  assign step_dn = ~mode_e & ((down_e & ~up_e) | rpt_dn);
  assign any_evt = mode_e | up_e | down_e | rpt_up | rpt_dn;
  assign tmo_hit = in_set & ~any_evt & (tmo_cnt == 30'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: runs only while editing, cleared by any activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          tmo_cnt <= '0;
    else if (!in_set || any_evt || tmo_hit) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 30'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Next-state: mode advances fields, COMMIT lasts one cycle, timeout aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mode_e) state_nxt = SET_HOUR;
      SET_HOUR: if (mode_e) state_nxt = SET_MIN; else if (tmo_hit) state_nxt = RUN;
      SET_MIN:  if (mode_e) state_nxt = SET_SEC; else if (tmo_hit) state_nxt = RUN;
      SET_SEC:  if (mode_e) state_nxt = COMMIT;  else if (tmo_hit) state_nxt = RUN;
      COMMIT:   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Edit registers: clamped capture on entry, modular up/down per field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour_r <= '0;
      min_r  <= '0;
      sec_r  <= '0;
    end else if (state == RUN && mode_e) begin
      hour_r <= (cur_hour   > 5'd23) ? 5'd0 : cur_hour;
      min_r  <= (cur_minute > 6'd59) ? 6'd0 : cur_minute;
      sec_r  <= (cur_second > 6'd59) ? 6'd0 : cur_second;
    end else begin
      case (state)
        SET_HOUR: begin
          if (step_up)      hour_r <= (hour_r == 5'd23) ? 5'd0  : hour_r + 5'd1;
          else if (step_dn) hour_r <= (hour_r == 5'd0)  ? 5'd23 : hour_r - 5'd1;
        end
        SET_MIN: begin
          if (step_up)      min_r <= (min_r == 6'd59) ? 6'd0  : min_r + 6'd1;
          else if (step_dn) min_r <= (min_r == 6'd0)  ? 6'd59 : min_r - 6'd1;
        end
        SET_SEC: begin
          if (step_up)      sec_r <= (sec_r == 6'd59) ? 6'd0  : sec_r + 6'd1;
          else if (step_dn) sec_r <= (sec_r == 6'd0)  ? 6'd59 : sec_r - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    sel_field = 2'd0;
    case (state)
      SET_HOUR: sel_field = 2'd1;
      SET_MIN:  sel_field = 2'd2;
      SET_SEC:  sel_field = 2'd3;
      default:  sel_field = 2'd0;
    endcase
  end

  assign set_active  = (state != RUN);
  assign load        = (state == COMMIT);
  assign load_hour   = hour_r;
  assign load_minute = min_r;
  assign load_second = sec_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed plan steps plus randomized button
// traffic checked every cycle against a field-level behavioural model.
module tb_clock_set_ctrl;
  localparam int TMO = 20;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] c_s = '0, c_m = '0;
  logic [4:0] c_h = '0;
  logic       set_active, load;
  logic [1:0] sel_field;
  logic [5:0] load_second, load_minute;
  logic [4:0] load_hour;

  int n_cmp = 0, n_bad = 0;

  // Model: st 0=run 1=hour 2=minute 3=second 4=commit
  int m_st, m_h, m_m, m_s, m_t;
  bit pm, pu, pd, m_known, model_on;

  clock_set_ctrl #(
`ifdef AUTO_REPEAT_EN
    .HOLD_CYCLES(10), .REPEAT_CYCLES(4),
`endif
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_second(c_s), .cur_minute(c_m), .cur_hour(c_h),
    .set_active(set_active), .sel_field(sel_field), .load(load),
    .load_second(load_second), .load_minute(load_minute), .load_hour(load_hour)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_t = 0;
    pm = 1; pu = 1; pd = 1; m_known = 1;
  endtask

  task automatic model_adj(input int d);
    case (m_st)
      1: m_h = (m_h + d + 24) % 24;
      2: m_m = (m_m + d + 60) % 60;
      3: m_s = (m_s + d + 60) % 60;
      default: ;
    endcase
  endtask

  task automatic model_clock(input bit bm, input bit bu, input bit bd);
    bit me, ue, de;
    me = bm & ~pm; ue = bu & ~pu; de = bd & ~pd;
    pm = bm; pu = bu; pd = bd;
    case (m_st)
      0: if (me) begin
        m_h = (c_h > 23) ? 0 : int'(c_h);
        m_m = (c_m > 59) ? 0 : int'(c_m);
        m_s = (c_s > 59) ? 0 : int'(c_s);
        m_known = 1; m_st = 1; m_t = 0;
      end
      1, 2, 3: begin
        if (me) begin m_st++; m_t = 0; end
        else if (ue || de) begin
          if (ue != de) model_adj(ue ? 1 : -1);
          m_t = 0;
        end
        else if (m_t == TMO - 1) begin m_st = 0; m_t = 0; m_known = 0; end
        else m_t++;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic model_check();
    int sel;
    sel = (m_st >= 1 && m_st <= 3) ? m_st : 0;
    chk("ctl", {29'd0, set_active, sel_field, load},
        {29'd0, (m_st != 0), 2'(sel), (m_st == 4)});
    if (m_known)
      chk("val", {15'd0, load_hour, load_minute, load_second},
          {15'd0, 5'(m_h), 6'(m_m), 6'(m_s)});
  endtask

  // One clock with the given button levels; outputs checked 1 time unit later.
  task automatic step(input bit bm, input bit bu, input bit bd);
    btn_mode = bm; btn_up = bu; btn_down = bd;
    @(posedge clk);
    if (model_on) model_clock(bm, bu, bd);
    #1;
    if (model_on) model_check();
  endtask

  task automatic press_mode();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic do_reset(input bit hold_mode);
    @(negedge clk);
    reset_n = 0; btn_mode = hold_mode; btn_up = 0; btn_down = 0;
    model_reset();
    #2;
    chk("rst_ctl", {set_active, sel_field, load}, 4'b0);
    chk("rst_val", {load_hour, load_minute, load_second}, 17'd0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    model_on = 1;
    model_reset();

    // Reset and idle RUN with cur = 12:34:56
    c_h = 12; c_m = 34; c_s = 56;
    do_reset(0);
    repeat (3) step(0, 0, 0);
    chk("run_idle_ctl", {set_active, sel_field, load}, 4'b0);
    chk("run_idle_val", {load_hour, load_minute, load_second}, 17'd0);
    step(0, 1, 0); step(0, 0, 1); step(0, 0, 0);
    chk("run_ignore_updn", {set_active, load_hour}, 6'd0);

    // Mode held through reset: no edge until re-pressed
    do_reset(1);
    step(1, 0, 0);
    chk("held_thru_reset", set_active, 0);

    // Main edit walk from 23:59:58
    c_h = 23; c_m = 59; c_s = 58;
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t2_sel_hour", sel_field, 1);
    chk("t2_cap_hour", load_hour, 23);
    step(0, 0, 0); step(0, 1, 0);
    chk("t2_hour_wrap", load_hour, 0);
    step(0, 0, 0); press_mode(); step(0, 0, 1);
    chk("t2_min_dn", load_minute, 58);
    step(0, 0, 0); press_mode(); step(0, 1, 0);
    chk("t2_sec_up", load_second, 59);
    step(0, 0, 0); step(1, 0, 0);
    chk("t2_commit_load", load, 1);
    chk("t2_commit_val", {load_hour, load_minute, load_second}, {5'd0, 6'd58, 6'd59});
    step(0, 0, 0);
    chk("t2_after_commit", {set_active, load}, 2'b00);
    chk("t2_retained", {load_hour, load_minute, load_second}, {5'd0, 6'd58, 6'd59});

    // Wraps and capture clamp, cur = 00:60:59
    c_h = 0; c_m = 60; c_s = 59;
    press_mode(); step(0, 0, 1);
    chk("t3_hour_0_dn", load_hour, 23);
    step(0, 0, 0); press_mode();
    chk("t3_min_clamp", load_minute, 0);
    step(0, 0, 1);
    chk("t3_min_0_dn", load_minute, 59);
    step(0, 0, 0); press_mode(); step(0, 1, 0);
    chk("t3_sec_59_up", load_second, 0);
    step(0, 0, 0); step(1, 0, 0);
    chk("t3_commit", {load, load_hour, load_minute, load_second}, {1'b1, 5'd23, 6'd59, 6'd0});
    step(0, 0, 0);

    // Simultaneous events, cur = 05:10:20
    c_h = 5; c_m = 10; c_s = 20;
    press_mode(); step(0, 1, 1);
    chk("t4_updn_same", load_hour, 5);
    step(0, 0, 0); step(1, 1, 0);
    chk("t4_mode_up_sel", sel_field, 2);
    chk("t4_mode_up_hour", load_hour, 5);
    step(0, 0, 0); press_mode(); step(1, 0, 0); step(0, 0, 0);

    // Inactivity timeout from SET_HOUR
    press_mode();
    repeat (18) step(0, 0, 0);
    chk("t5_pre_timeout", {set_active, sel_field}, 3'b101);
    step(0, 0, 0);
    chk("t5_timeout", {set_active, load}, 2'b00);
    repeat (3) step(0, 0, 0);

    // Reset mid-edit in SET_MIN
    c_h = 7; c_m = 8; c_s = 9;
    press_mode(); press_mode();
    chk("t5_in_min", sel_field, 2);
    #2 reset_n = 0;
    #1;
    chk("t5_async_rst", {set_active, sel_field, load}, 4'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    repeat (3) step(0, 0, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      bit bm, bu, bd;
      c_h = 5'($urandom_range(0, 31));
      c_m = 6'($urandom_range(0, 63));
      c_s = 6'($urandom_range(0, 63));
      bm = ($urandom_range(0, 3) == 0);
      bu = $urandom_range(0, 1) == 1;
      bd = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(1, 3)) step(bm, bu, bd);
      repeat ($urandom_range(1, 2)) step(0, 0, 0);
      if ($urandom_range(0, 15) == 0) repeat (TMO + 2) step(0, 0, 0);
    end

`ifdef AUTO_REPEAT_EN
    // Hold-to-repeat: up held 20 cycles in SET_SEC starting from 10
    do_reset(0);
    c_h = 0; c_m = 0; c_s = 10;
    press_mode(); press_mode(); press_mode();
    chk("t6_in_sec", {sel_field, load_second}, {2'd3, 6'd10});
    model_on = 0;
    for (int k = 1; k <= 20; k++) begin
      int e;
      step(0, 1, 0);
      e = 11 + (k >= 11 ? 1 : 0) + (k >= 15 ? 1 : 0) + (k >= 19 ? 1 : 0);
      chk($sformatf("t6_rpt_%0d", k), load_second, e);
    end
    step(0, 0, 0);
    chk("t6_final", load_second, 14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
